hpi_io_bridge: RTL and testbench

Registered timing bridge between the SoC's OTG HPI PIO exports and the physical CY7C67200 host-port pins. Software bit-bangs HPI cycles through the PIOs; this block re-times each request into a clean address-setup / strobe / hold sequence with guaranteed minimum widths. It drives the shared data bus only during writes and captures read data at the end of the read strobe. It sits between the SoC instance and the top-level pins, and the top level owns the tristate buffer.

---
 rtl/hpi_pkg.sv | 37 +++
 rtl/hpi_io_bridge_if.sv | 40 ++++
 rtl/hpi_io_bridge.sv | 195 +++++++++++++++++++
 tb/tb_hpi_io_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI host-port bridge: FSM states,
// default timing, and the four HPI register-select encodings.
package hpi_pkg;

  localparam int HPI_DATA_W      = 16;
  localparam int HPI_ADDR_W      = 2;

  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_STROBE_CYC  = 4;
  localparam int DEF_HOLD_CYC    = 2;
  localparam int DEF_CNT_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RELEASE
  } hpi_state_e;

  typedef enum logic [HPI_ADDR_W-1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDRESS = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_addr_e;

  // A bus cycle is requested only with cs low and exactly one of r/w low.
  function automatic logic hpi_req_valid(input logic cs_n, input logic r_n, input logic w_n);
    return !cs_n && (r_n != w_n);
  endfunction

  function automatic logic hpi_req_conflict(input logic cs_n, input logic r_n, input logic w_n);
    return !cs_n && !r_n && !w_n;
  endfunction

endpackage

// File: rtl/hpi_io_bridge_if.sv
// SoC-side PIO exports and chip-side HPI pins of the bridge, bundled as one
// interface; the bridge is the slave, the SoC/pin environment is the master.
interface hpi_io_bridge_if;
  import hpi_pkg::*;

  logic [HPI_ADDR_W-1:0] otg_hpi_address_export;
  logic [HPI_DATA_W-1:0] otg_hpi_data_out_port;
  logic                  otg_hpi_r_export;
  logic                  otg_hpi_w_export;
  logic                  otg_hpi_cs_export;
  logic                  otg_hpi_reset_export;
  logic [HPI_DATA_W-1:0] otg_hpi_data_in_port;

  logic [HPI_ADDR_W-1:0] otg_addr;
  logic [HPI_DATA_W-1:0] otg_data_o;
  logic                  otg_data_oe;
  logic [HPI_DATA_W-1:0] otg_data_i;
  logic                  otg_rd_n;
  logic                  otg_wr_n;
  logic                  otg_cs_n;
  logic                  otg_rst_n;
  logic                  hpi_err;

  modport master (
    output otg_hpi_address_export, otg_hpi_data_out_port,
    output otg_hpi_r_export, otg_hpi_w_export, otg_hpi_cs_export, otg_hpi_reset_export,
    output otg_data_i,
    input  otg_hpi_data_in_port, otg_addr, otg_data_o, otg_data_oe,
    input  otg_rd_n, otg_wr_n, otg_cs_n, otg_rst_n, hpi_err
  );

  modport slave (
    input  otg_hpi_address_export, otg_hpi_data_out_port,
    input  otg_hpi_r_export, otg_hpi_w_export, otg_hpi_cs_export, otg_hpi_reset_export,
    input  otg_data_i,
    output otg_hpi_data_in_port, otg_addr, otg_data_o, otg_data_oe,
    output otg_rd_n, otg_wr_n, otg_cs_n, otg_rst_n, hpi_err
  );

endinterface

// File: rtl/hpi_io_bridge.sv
// Re-times software bit-banged HPI requests into a clean setup/strobe/hold
// bus cycle with guaranteed minimum widths; the tristate lives at the top level.
module hpi_io_bridge
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  hpi_io_bridge_if.slave hpi
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [HPI_ADDR_W-1:0] addr_in_d, addr_in_q;
  logic [HPI_DATA_W-1:0] wdata_in_d, wdata_in_q;
  logic                  r_in_d, r_in_q;
  logic                  w_in_d, w_in_q;
  logic                  cs_in_d, cs_in_q;
  logic                  rst_in_d, rst_in_q;

  hpi_state_e            state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic                  is_rd_d, is_rd_q;
  logic [HPI_ADDR_W-1:0] addr_d, addr_q;
  logic [HPI_DATA_W-1:0] data_o_d, data_o_q;
  logic [HPI_DATA_W-1:0] data_in_d, data_in_q;
  logic                  oe_d, oe_q;
  logic                  rd_n_d, rd_n_q;
  logic                  wr_n_d, wr_n_q;
  logic                  cs_n_d, cs_n_q;
  logic                  err_d, err_q;

  logic                  req_ok;
  logic                  req_conflict;
  logic                  cnt_done;

  // Input stage: every SoC export is registered once before the FSM looks at it.
  always_comb begin
    addr_in_d  = hpi.otg_hpi_address_export;
    wdata_in_d = hpi.otg_hpi_data_out_port;
    r_in_d     = hpi.otg_hpi_r_export;
    w_in_d     = hpi.otg_hpi_w_export;
    cs_in_d    = hpi.otg_hpi_cs_export;
    rst_in_d   = hpi.otg_hpi_reset_export;
  end

  always_ff @(posedge clk_clk) begin
    addr_in_q  <= addr_in_d;
    wdata_in_q <= wdata_in_d;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_in_q   <= 1'b1;
      w_in_q   <= 1'b1;
      cs_in_q  <= 1'b1;
      rst_in_q <= 1'b1;
    end else begin
      r_in_q   <= r_in_d;
      w_in_q   <= w_in_d;
      cs_in_q  <= cs_in_d;
      rst_in_q <= rst_in_d;
    end
  end

  assign req_ok       = hpi_req_valid(cs_in_q, r_in_q, w_in_q);
  assign req_conflict = hpi_req_conflict(cs_in_q, r_in_q, w_in_q);
  assign cnt_done     = (cnt_q <= CNT_ONE);

  // Bus-cycle sequencer: next values for every registered pin.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    data_o_d  = data_o_q;
    data_in_d = data_in_q;
    oe_d      = oe_q;
    rd_n_d    = rd_n_q;
    wr_n_d    = wr_n_q;
    cs_n_d    = cs_n_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          is_rd_d = !r_in_q;
          addr_d  = addr_in_q;
          cs_n_d  = 1'b0;
          oe_d    = r_in_q;
          if (r_in_q) begin
            data_o_d = wdata_in_q;
          end
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end else if (req_conflict) begin
          err_d = 1'b1;
        end
      end

      SETUP: begin
        if (cnt_done) begin
          rd_n_d  = !is_rd_q;
          wr_n_d  = is_rd_q;
          cnt_d   = STROBE_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      STROBE: begin
        if (cnt_done) begin
          rd_n_d = 1'b1;
          wr_n_d = 1'b1;
          // Sample the chip's drive on the same edge the read strobe rises.
          if (is_rd_q) begin
            data_in_d = hpi.otg_data_i;
          end
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      HOLD: begin
        if (cnt_done) begin
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      RELEASE: begin
        // Wait for software to drop the request so one request makes one strobe.
        if (cs_in_q || (r_in_q && w_in_q)) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      data_o_q  <= '0;
      data_in_q <= '0;
      oe_q      <= 1'b0;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      data_o_q  <= data_o_d;
      data_in_q <= data_in_d;
      oe_q      <= oe_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      cs_n_q    <= cs_n_d;
      err_q     <= err_d;
    end
  end

  assign hpi.otg_hpi_data_in_port = data_in_q;
  assign hpi.otg_addr             = addr_q;
  assign hpi.otg_data_o           = data_o_q;
  assign hpi.otg_data_oe          = oe_q;
  assign hpi.otg_rd_n             = rd_n_q;
  assign hpi.otg_wr_n             = wr_n_q;
  assign hpi.otg_cs_n             = cs_n_q;
  assign hpi.otg_rst_n            = rst_in_q;
  assign hpi.hpi_err              = err_q;

endmodule

// File: tb/tb_hpi_io_bridge.sv
// Directed bench for hpi_io_bridge: drives HPI requests from the SoC side and
// checks pin timing cycle by cycle against hand-derived expectations.
module tb_hpi_io_bridge;
  import hpi_pkg::*;

  logic clk_clk = 1'b0;
  logic reset_reset_n;

  always #5 clk_clk = ~clk_clk;

  hpi_io_bridge_if bus ();

  hpi_io_bridge dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .hpi           (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic        cs_s   [32];
  logic        rd_s   [32];
  logic        wr_s   [32];
  logic        oe_s   [32];
  logic        rst_s  [32];
  logic        err_s  [32];
  logic [1:0]  addr_s [32];
  logic [15:0] do_s   [32];
  logic [15:0] di_s   [32];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic sample(input int i);
    cs_s[i]   = bus.otg_cs_n;
    rd_s[i]   = bus.otg_rd_n;
    wr_s[i]   = bus.otg_wr_n;
    oe_s[i]   = bus.otg_data_oe;
    rst_s[i]  = bus.otg_rst_n;
    err_s[i]  = bus.hpi_err;
    addr_s[i] = bus.otg_addr;
    do_s[i]   = bus.otg_data_o;
    di_s[i]   = bus.otg_hpi_data_in_port;
  endtask

  // Inputs applied 1ns after edge 0; sample i is taken 1ns after edge i.
  task automatic run_cycle(input logic is_rd, input logic conflict, input logic [1:0] a,
                           input logic [15:0] d, input int hold, input int n,
                           input int rst_at, input int rst_rel,
                           input int crst_lo, input int crst_hi, input int beef_at);
    @(posedge clk_clk); #1;
    bus.otg_hpi_address_export = a;
    bus.otg_hpi_data_out_port  = d;
    bus.otg_hpi_cs_export      = 1'b0;
    bus.otg_hpi_r_export       = !(is_rd || conflict);
    bus.otg_hpi_w_export       = is_rd && !conflict;
    bus.otg_data_i             = 16'h0000;
    sample(0);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk_clk); #1;
      sample(i);
      if (i == hold) begin
        bus.otg_hpi_cs_export = 1'b1;
        bus.otg_hpi_r_export  = 1'b1;
        bus.otg_hpi_w_export  = 1'b1;
      end
      if (i == rst_at)  reset_reset_n = 1'b0;
      if (i == rst_rel) reset_reset_n = 1'b1;
      if (i == crst_lo) bus.otg_hpi_reset_export = 1'b0;
      if (i == crst_hi) bus.otg_hpi_reset_export = 1'b1;
      if (i == beef_at) bus.otg_data_i = 16'hBEEF;
    end
  endtask

  function automatic int wr_falls(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (wr_s[i-1] && !wr_s[i]) c++;
    return c;
  endfunction

  function automatic int rd_falls(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (rd_s[i-1] && !rd_s[i]) c++;
    return c;
  endfunction

  function automatic int count_low(input int n, input int which);
    int c = 0;
    for (int i = 0; i <= n; i++) begin
      case (which)
        0: if (!cs_s[i])  c++;
        1: if (!wr_s[i])  c++;
        2: if (!rst_s[i]) c++;
        default: if (oe_s[i]) c++;
      endcase
    end
    return c;
  endfunction

  initial begin
    bus.otg_hpi_address_export = 2'd0;
    bus.otg_hpi_data_out_port  = 16'h0000;
    bus.otg_hpi_cs_export      = 1'b1;
    bus.otg_hpi_r_export       = 1'b1;
    bus.otg_hpi_w_export       = 1'b1;
    bus.otg_hpi_reset_export   = 1'b1;
    bus.otg_data_i             = 16'h0000;
    reset_reset_n              = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check_val("rst_cs_n",  32'(bus.otg_cs_n), 32'd1);
    check_val("rst_rd_n",  32'(bus.otg_rd_n), 32'd1);
    check_val("rst_wr_n",  32'(bus.otg_wr_n), 32'd1);
    check_val("rst_rst_n", 32'(bus.otg_rst_n), 32'd1);
    check_val("rst_oe",    32'(bus.otg_data_oe), 32'd0);
    check_val("rst_addr",  32'(bus.otg_addr), 32'd0);
    check_val("rst_do",    32'(bus.otg_data_o), 32'd0);
    check_val("rst_di",    32'(bus.otg_hpi_data_in_port), 32'd0);
    check_val("rst_err",   32'(bus.hpi_err), 32'd0);
    reset_reset_n = 1'b1;

    // Write held for 20 cycles: exactly one 4-cycle strobe.
    run_cycle(1'b0, 1'b0, 2'd2, 16'h1234, 20, 26, -1, -1, -1, -1, -1);
    check_val("wr_cs_s1",   32'(cs_s[1]), 32'd1);
    check_val("wr_cs_s2",   32'(cs_s[2]), 32'd0);
    check_val("wr_cs_s9",   32'(cs_s[9]), 32'd0);
    check_val("wr_cs_s10",  32'(cs_s[10]), 32'd1);
    check_val("wr_wr_s3",   32'(wr_s[3]), 32'd1);
    check_val("wr_wr_s4",   32'(wr_s[4]), 32'd0);
    check_val("wr_wr_s7",   32'(wr_s[7]), 32'd0);
    check_val("wr_wr_s8",   32'(wr_s[8]), 32'd1);
    check_val("wr_pulses",  32'(wr_falls(26)), 32'd1);
    check_val("wr_low_cnt", 32'(count_low(26, 1)), 32'd4);
    check_val("wr_oe_cnt",  32'(count_low(26, 3)), 32'd8);
    check_val("wr_oe_s2",   32'(oe_s[2]), 32'd1);
    check_val("wr_oe_s9",   32'(oe_s[9]), 32'd1);
    check_val("wr_data",    32'(do_s[5]), 32'h1234);
    check_val("wr_addr",    32'(addr_s[5]), 32'd2);
    check_val("wr_no_rd",   32'(rd_falls(26)), 32'd0);

    // Read: chip drives BEEF late in the strobe, captured as rd_n rises.
    run_cycle(1'b1, 1'b0, 2'd0, 16'h0000, 3, 14, -1, -1, -1, -1, 6);
    check_val("rd_rd_s3",   32'(rd_s[3]), 32'd1);
    check_val("rd_rd_s4",   32'(rd_s[4]), 32'd0);
    check_val("rd_rd_s7",   32'(rd_s[7]), 32'd0);
    check_val("rd_rd_s8",   32'(rd_s[8]), 32'd1);
    check_val("rd_di_s7",   32'(di_s[7]), 32'h0000);
    check_val("rd_di_s8",   32'(di_s[8]), 32'hBEEF);
    check_val("rd_di_s9",   32'(di_s[9]), 32'hBEEF);
    check_val("rd_oe_cnt",  32'(count_low(14, 3)), 32'd0);
    check_val("rd_no_wr",   32'(wr_falls(14)), 32'd0);
    check_val("rd_addr",    32'(addr_s[4]), 32'd0);
    check_val("rd_cs_s10",  32'(cs_s[10]), 32'd1);

    // Back-to-back writes with the request released in between.
    run_cycle(1'b0, 1'b0, 2'd1, 16'hAAAA, 3, 12, -1, -1, -1, -1, -1);
    check_val("b2b1_pulses", 32'(wr_falls(12)), 32'd1);
    check_val("b2b1_data",   32'(do_s[5]), 32'hAAAA);
    check_val("b2b1_di",     32'(di_s[5]), 32'hBEEF);
    run_cycle(1'b0, 1'b0, 2'd3, 16'h5555, 3, 12, -1, -1, -1, -1, -1);
    check_val("b2b2_pulses", 32'(wr_falls(12)), 32'd1);
    check_val("b2b2_wr_s4",  32'(wr_s[4]), 32'd0);
    check_val("b2b2_data",   32'(do_s[5]), 32'h5555);
    check_val("b2b2_addr",   32'(addr_s[5]), 32'd3);

    // Conflict: r and w low together.
    run_cycle(1'b0, 1'b1, 2'd0, 16'h0000, 4, 10, -1, -1, -1, -1, -1);
    check_val("cf_cs_low",  32'(count_low(10, 0)), 32'd0);
    check_val("cf_no_wr",   32'(wr_falls(10)), 32'd0);
    check_val("cf_no_rd",   32'(rd_falls(10)), 32'd0);
    check_val("cf_err_s1",  32'(err_s[1]), 32'd0);
    check_val("cf_err_s2",  32'(err_s[2]), 32'd1);
    check_val("cf_err_s10", 32'(err_s[10]), 32'd1);

    // Chip reset pass-through during a write cycle.
    run_cycle(1'b0, 1'b0, 2'd0, 16'h0F0F, 3, 14, -1, -1, 1, 6, -1);
    check_val("cr_rst_s1",  32'(rst_s[1]), 32'd1);
    check_val("cr_rst_s2",  32'(rst_s[2]), 32'd0);
    check_val("cr_rst_s6",  32'(rst_s[6]), 32'd0);
    check_val("cr_rst_s7",  32'(rst_s[7]), 32'd1);
    check_val("cr_rst_cnt", 32'(count_low(14, 2)), 32'd5);
    check_val("cr_pulses",  32'(wr_falls(14)), 32'd1);
    check_val("cr_wr_s8",   32'(wr_s[8]), 32'd1);
    check_val("cr_cs_s10",  32'(cs_s[10]), 32'd1);
    check_val("cr_data",    32'(do_s[5]), 32'h0F0F);
    check_val("cr_err",     32'(err_s[14]), 32'd1);

    // System reset in the middle of a write strobe.
    run_cycle(1'b0, 1'b0, 2'd2, 16'h7777, 5, 12, 5, 6, -1, -1, -1);
    check_val("mr_wr_s5",   32'(wr_s[5]), 32'd0);
    check_val("mr_wr_s6",   32'(wr_s[6]), 32'd1);
    check_val("mr_cs_s6",   32'(cs_s[6]), 32'd1);
    check_val("mr_oe_s6",   32'(oe_s[6]), 32'd0);
    check_val("mr_di_s6",   32'(di_s[6]), 32'h0000);
    check_val("mr_do_s6",   32'(do_s[6]), 32'h0000);
    check_val("mr_err_s6",  32'(err_s[6]), 32'd0);
    check_val("mr_wr_low",  32'(count_low(12, 1)), 32'd2);
    check_val("mr_state",   32'(dut.state_q), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
